// File: rtl/water_dispenser_pkg.sv
// Shared types and defaults for the water dispenser control path.
package water_dispenser_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DISPENSE   = 3'd2,
    COOL_START = 3'd3,
    COOLDOWN   = 3'd4
  } state_t;

  localparam int unsigned DEFAULT_DISPENSE_COUNT = 18;
  localparam int unsigned DEFAULT_COOLDOWN_COUNT = 50;

endpackage

// File: rtl/button_synchronizer.sv
// Two-flop synchronizer for the raw push button followed by a rising-edge
// detector; rise is high for exactly one cycle per synchronized low-to-high.
module button_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // Metastability chain plus previous-value register for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign rise = sync_2 & ~sync_prev;

endmodule

// File: rtl/dispense_controller.sv
// Pour/cooldown control FSM in front of the external timing counter.
// Optional feature macro: WATER_DISPENSER_CUP_ABORT_EN (abort a pour when the
// cup is removed during START or DISPENSE).
module dispense_controller
  import water_dispenser_pkg::*;
#(
  parameter int unsigned BIT_COUNT      = 32,
  parameter int unsigned DISPENSE_COUNT = DEFAULT_DISPENSE_COUNT,
  parameter int unsigned COOLDOWN_COUNT = DEFAULT_COOLDOWN_COUNT,
  parameter int unsigned SERVED_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    button,
  input  logic                    cup_present,
  input  logic [BIT_COUNT-1:0]    count,
  output logic                    counter_clear,
  output logic                    valve_open,
  output logic                    busy,
  output logic                    done,
  output logic [SERVED_WIDTH-1:0] served
);

  // Last count value of each timed phase.
  localparam logic [BIT_COUNT-1:0] DISPENSE_LAST = BIT_COUNT'(DISPENSE_COUNT - 1);
  localparam logic [BIT_COUNT-1:0] COOLDOWN_LAST = BIT_COUNT'(COOLDOWN_COUNT - 1);
  // Count one cycle before the final DISPENSE cycle (only meaningful when
  // DISPENSE_COUNT >= 2; the single-count case is handled from START).
  localparam logic [BIT_COUNT-1:0] DISPENSE_PRE =
    BIT_COUNT'((DISPENSE_COUNT >= 2) ? (DISPENSE_COUNT - 2) : 0);

  state_t state;
  state_t next_state;
  logic   press;
  logic   done_next;

  button_synchronizer u_button_synchronizer (
    .clock (clock),
    .reset (reset),
    .in    (button),
    .rise  (press)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. done is registered, so it is raised one cycle early:
  // the counter advances by one per cycle, so the cycle before the final
  // DISPENSE count is known from the current count.
  always_comb begin
    next_state = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (press && cup_present) begin
          next_state = START;
        end
      end
      START: begin
        next_state = DISPENSE;
`ifdef WATER_DISPENSER_CUP_ABORT_EN
        if (!cup_present) begin
          next_state = COOL_START;
        end
`endif
        if ((DISPENSE_COUNT == 1) && (next_state == DISPENSE)) begin
          done_next = 1'b1;
        end
      end
      DISPENSE: begin
        if (count >= DISPENSE_LAST) begin
          next_state = COOL_START;
        end else begin
`ifdef WATER_DISPENSER_CUP_ABORT_EN
          if (!cup_present) begin
            next_state = COOL_START;
          end
`endif
          if ((next_state == DISPENSE) && (count >= DISPENSE_PRE)) begin
            done_next = 1'b1;
          end
        end
      end
      COOL_START: begin
        next_state = COOLDOWN;
      end
      COOLDOWN: begin
        if (count >= COOLDOWN_LAST) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    counter_clear = 1'b1;
    valve_open    = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE:       counter_clear = 1'b1;
      START: begin
        counter_clear = 1'b1;
        valve_open    = 1'b1;
      end
      DISPENSE: begin
        counter_clear = 1'b0;
        valve_open    = 1'b1;
      end
      COOL_START: counter_clear = 1'b1;
      COOLDOWN:   counter_clear = 1'b0;
      default:    counter_clear = 1'b1;
    endcase
  end

  // Registered done pulse, high during the final DISPENSE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else begin
      done <= done_next;
    end
  end

  // Saturating tally of completed pours, advanced on the done cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      served <= '0;
    end else if (done && (served != '1)) begin
      served <= served + 1'b1;
    end
  end

endmodule

// File: tb/tb_dispense_controller.sv
// Directed self-checking bench: dispense_controller driven against a simple
// behavioural counter, 20 ns clock, outputs sampled on the falling edge.
module tb_dispense_controller;

  logic        clock;
  logic        reset;
  logic        button;
  logic        cup_present;
  logic [31:0] count;
  logic        counter_clear;
  logic        valve_open;
  logic        busy;
  logic        done;
  logic [15:0] served;

  int tests;
  int fails;
  int hold_len;
  int cyc;

  dispense_controller #(
    .BIT_COUNT      (32),
    .DISPENSE_COUNT (18),
    .COOLDOWN_COUNT (50),
    .SERVED_WIDTH   (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .button        (button),
    .cup_present   (cup_present),
    .count         (count),
    .counter_clear (counter_clear),
    .valve_open    (valve_open),
    .busy          (busy),
    .done          (done),
    .served        (served)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Counter partner: 0 on the cycle after counter_clear, then +1 per cycle.
  always_ff @(posedge clock) begin
    if (counter_clear) count <= '0;
    else               count <= count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One falling edge; releases the button once it has been held hold_len cycles.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (cyc >= hold_len) button = 1'b0;
  endtask

  // Runs one pour from a press already launched; optionally drops the cup at a
  // given DISPENSE count. Reports valve-open cycles, done pulses, the count seen
  // with done, and busy cycles after the valve closes.
  task automatic run_pour(input int drop_at, output int open_n, output int done_n,
                          output int done_cnt, output int busy_n);
    int guard;
    open_n = 0; done_n = 0; done_cnt = -1; busy_n = 0; guard = 0;
    while (!valve_open && guard < 10) begin
      tick();
      guard++;
    end
    while (valve_open && open_n < 100) begin
      open_n++;
      if (done) begin
        done_n++;
        done_cnt = int'(count);
      end
      if (drop_at >= 0 && !counter_clear && count == 32'(drop_at)) cup_present = 1'b0;
      tick();
    end
    while (busy && busy_n < 200) begin
      busy_n++;
      if (done) done_n++;
      tick();
    end
  endtask

  initial begin
    int open_n, done_n, done_cnt, busy_n, guard;
    logic any;
    tests = 0; fails = 0; hold_len = 0; cyc = 0;
    reset = 1'b0; button = 1'b0; cup_present = 1'b0;

    // 1. Reset for 3 cycles, then release.
    repeat (3) @(negedge clock);
    check_bit("rst_valve", valve_open, 1'b0);
    check_bit("rst_clear", counter_clear, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check("rst_served", 32'(served), 0);
    reset = 1'b1;
    tick();
    check_bit("post_rst_valve", valve_open, 1'b0);
    check_bit("post_rst_clear", counter_clear, 1'b1);
    check_bit("post_rst_busy", busy, 1'b0);

    // 3. Press without a cup: ignored.
    cup_present = 1'b0;
    button = 1'b1; cyc = 0; hold_len = 3;
    any = 1'b0;
    repeat (10) begin
      tick();
      if (valve_open || busy) any = 1'b1;
    end
    check_bit("nocup_no_activity", any, 1'b0);
    check("nocup_served", 32'(served), 0);

    // 2. Normal pour, button held 5 cycles.
    cup_present = 1'b1;
    button = 1'b1; cyc = 0; hold_len = 5;
    run_pour(-1, open_n, done_n, done_cnt, busy_n);
    check("pour_open_cycles", 32'(open_n), 19);
    check("pour_done_pulses", 32'(done_n), 1);
    check("pour_done_count", 32'(done_cnt), 17);
    check("pour_busy_after", 32'(busy_n), 51);
    check("pour_served", 32'(served), 1);
    check_bit("pour_idle_clear", counter_clear, 1'b1);

    // 4. Presses during DISPENSE and COOLDOWN ignored; held button no retrigger.
    button = 1'b1; cyc = 0; hold_len = 3;
    guard = 0;
    while (!valve_open && guard < 10) begin
      tick();
      guard++;
    end
    open_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (valve_open) open_n++;
      tick();
    end
    button = 1'b1; cyc = 0; hold_len = 3;
    guard = 0;
    while (valve_open && guard < 100) begin
      open_n++;
      tick();
      guard++;
    end
    check("ign_open_cycles", 32'(open_n), 19);
    repeat (10) tick();
    check_bit("ign_in_cooldown", busy, 1'b1);
    button = 1'b1; cyc = 0; hold_len = 100000;
    guard = 0;
    while (busy && guard < 100) begin
      tick();
      guard++;
    end
    check_bit("ign_back_idle", busy, 1'b0);
    any = 1'b0;
    repeat (8) begin
      tick();
      if (busy || valve_open) any = 1'b1;
    end
    check_bit("ign_held_no_retrigger", any, 1'b0);
    check("ign_served", 32'(served), 2);
    button = 1'b0;
    repeat (3) tick();
    button = 1'b1; cyc = 0; hold_len = 2;
    run_pour(-1, open_n, done_n, done_cnt, busy_n);
    check("fresh_open_cycles", 32'(open_n), 19);
    check("fresh_served", 32'(served), 3);

    // 5. Reset asserted at DISPENSE count 7.
    button = 1'b1; cyc = 0; hold_len = 2;
    guard = 0;
    while (!(valve_open && !counter_clear && count == 32'd7) && guard < 40) begin
      tick();
      guard++;
    end
    check("midrst_reached", count, 7);
    check_bit("midrst_valve_before", valve_open, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_bit("midrst_valve", valve_open, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_done", done, 1'b0);
    check_bit("midrst_clear", counter_clear, 1'b1);
    check("midrst_served", 32'(served), 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    check_bit("midrst_idle", busy, 1'b0);
    check("midrst_served_after", 32'(served), 0);

    // 6. Cup removed at DISPENSE count 5.
    cup_present = 1'b1;
    button = 1'b1; cyc = 0; hold_len = 2;
    run_pour(5, open_n, done_n, done_cnt, busy_n);
`ifdef WATER_DISPENSER_CUP_ABORT_EN
    check("cupdrop_open_cycles", 32'(open_n), 7);
    check("cupdrop_done_pulses", 32'(done_n), 0);
    check("cupdrop_served", 32'(served), 0);
`else
    check("cupdrop_open_cycles", 32'(open_n), 19);
    check("cupdrop_done_pulses", 32'(done_n), 1);
    check("cupdrop_served", 32'(served), 1);
`endif
    check("cupdrop_busy_after", 32'(busy_n), 51);
    cup_present = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
